// File: rtl/axis_packet_framer_pkg.sv
// Shared types and constants for the AXI-Stream packet framer and its FIFO.
package axis_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } framer_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  localparam int PTR_W = clog2(DEPTH_DEF) + 1;

endpackage

// File: rtl/axis_packet_framer_if.sv
// AXI-Stream beat bundle; master drives data/valid/last, slave drives ready.
interface axis_if
  import axis_pkg::*;
#(
  parameter int W = DATA_WIDTH_DEF
);
  logic [W-1:0] data;
  logic         valid;
  logic         last;
  logic         ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_packet_framer_fifo.sv
// Synchronous FIFO with extra pointer MSB for full/empty and zeroed head when empty.
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int Width = 9,
  parameter int Depth = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [Width-1:0]        wdata,
  input  logic                    pop,
  output logic [Width-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(Depth):0]   count
);
  localparam int AW = clog2(Depth);
  localparam int PW = AW + 1;

  logic [Width-1:0] mem_r [Depth];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic             push_s;
  logic             pop_s;

  assign count  = wr_ptr_r - rd_ptr_r;
  assign full   = (count == PW'(Depth));
  assign empty  = (count == PW'(0));
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign rdata  = empty ? {Width{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer state; reset discards any buffered beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? rd_ptr_r + PW'(1) : rd_ptr_r;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end
endmodule

// File: rtl/axis_packet_framer.sv
// Buffers an AXI-Stream byte stream and re-cuts it into len-beat packets.
module axis_packet_framer
  import axis_pkg::*;
#(
  parameter int Data_width = DATA_WIDTH_DEF,
  parameter int Depth      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_if.slave                 s_axis,
  axis_if.master                m_axis,
  input  logic [Data_width-1:0] len,
  output logic                  full,
  output logic                  empty,
  output logic [Data_width-1:0] pkt_count
);
  localparam int CW = clog2(Depth) + 1;
  localparam logic [Data_width-1:0] ONE = Data_width'(1);

  logic [Data_width:0]   head_s;
  logic [CW-1:0]         count_s;
  logic                  head_last_s;
  logic                  pop_s;
  logic                  last_s;
  logic [Data_width-1:0] eff_len_s;
  framer_state_t         state_r, state_nx;
  logic [Data_width-1:0] beat_cnt_r, beat_cnt_nx;
  logic [Data_width-1:0] len_q_r, len_q_nx;
  logic [Data_width-1:0] pkt_count_r, pkt_count_nx;

  axis_sync_fifo #(.Width(Data_width + 1), .Depth(Depth)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_axis.valid && s_axis.ready),
    .wdata ({s_axis.last, s_axis.data}),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full),
    .empty (empty),
    .count (count_s)
  );

  // Ready/valid come from the registered count only, never from m_ready.
  assign s_axis.ready = rst && (count_s != CW'(Depth));
  assign m_axis.valid = !empty;
  assign m_axis.data  = head_s[Data_width-1:0];
  assign m_axis.last  = !empty && last_s;
  assign head_last_s  = head_s[Data_width];
  assign pop_s        = !empty && m_axis.ready;
  assign eff_len_s    = (len == Data_width'(0)) ? ONE : len;
  assign pkt_count    = pkt_count_r;

  // Framing state and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      beat_cnt_r  <= Data_width'(0);
      len_q_r     <= ONE;
      pkt_count_r <= Data_width'(0);
    end else begin
      state_r     <= state_nx;
      beat_cnt_r  <= beat_cnt_nx;
      len_q_r     <= len_q_nx;
      pkt_count_r <= pkt_count_nx;
    end
  end

  // Next-state, packet boundary and packet counter; len is only sampled on a first beat.
  always_comb begin
    state_nx     = state_r;
    beat_cnt_nx  = beat_cnt_r;
    len_q_nx     = len_q_r;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        last_s = head_last_s || (eff_len_s == ONE);
        if (pop_s) begin
          len_q_nx    = eff_len_s;
          beat_cnt_nx = ONE;
          state_nx    = last_s ? IDLE : ACTIVE;
        end else begin
          state_nx = IDLE;
        end
      end
      ACTIVE: begin
        last_s = head_last_s || (beat_cnt_r == len_q_r - ONE);
        if (pop_s) begin
          beat_cnt_nx = beat_cnt_r + ONE;
          state_nx    = last_s ? IDLE : ACTIVE;
        end else begin
          state_nx = ACTIVE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (pop_s && last_s) begin
      pkt_count_nx = pkt_count_r + ONE;
    end else begin
      pkt_count_nx = pkt_count_r;
    end
  end
endmodule

// File: tb/tb_axis_packet_framer.sv
// Directed-vector bench for axis_packet_framer with a popped-beat monitor.
module tb_axis_packet_framer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] len;
  logic       full;
  logic       empty;
  logic [7:0] pkt_count;
  int         n_vec = 0;
  int         n_err = 0;

  logic [7:0] obs_d [$];
  logic       obs_l [$];
  logic [7:0] exp_d [$];
  logic       exp_l [$];

  axis_if #(.W(8)) s_bus ();
  axis_if #(.W(8)) m_bus ();

  axis_packet_framer #(.Data_width(8), .Depth(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (s_bus),
    .m_axis    (m_bus),
    .len       (len),
    .full      (full),
    .empty     (empty),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  // Record every handshaken output beat midway through the cycle.
  always @(negedge clk) begin
    if (m_bus.valid && m_bus.ready) begin
      obs_d.push_back(m_bus.data);
      obs_l.push_back(m_bus.last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [7:0] d, input logic l);
    logic acc;
    acc = 1'b0;
    s_bus.valid = 1'b1;
    s_bus.data  = d;
    s_bus.last  = l;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = s_bus.ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("push_timeout", 32'(s_bus.ready), 32'd1);
  endtask

  task automatic idle();
    s_bus.valid = 1'b0;
    s_bus.last  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && !empty; k++) step();
    chk("drain_empty", 32'(empty), 32'd1);
  endtask

  task automatic add_exp(input logic [7:0] d, input logic l);
    exp_d.push_back(d);
    exp_l.push_back(l);
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_beats"}, 32'(obs_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(obs_d[i]), 32'(exp_d[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(obs_l[i]), 32'(exp_l[i]));
    end
    obs_d.delete(); obs_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  initial begin
    s_bus.valid = 1'b0;
    s_bus.data  = 8'h00;
    s_bus.last  = 1'b0;
    m_bus.ready = 1'b0;
    len         = 8'd4;
    #12;
    chk("rst_s_ready", 32'(s_bus.ready), 32'd0);
    chk("rst_m_valid", 32'(m_bus.valid), 32'd0);
    chk("rst_m_last",  32'(m_bus.last),  32'd0);
    chk("rst_m_data",  32'(m_bus.data),  32'd0);
    chk("rst_full",    32'(full),        32'd0);
    chk("rst_empty",   32'(empty),       32'd1);
    chk("rst_pkt",     32'(pkt_count),   32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    chk("t1_ready_after_rst", 32'(s_bus.ready), 32'd1);

    // Two fixed-length packets, streaming.
    m_bus.ready = 1'b1;
    chk("t1_mvalid_pre", 32'(m_bus.valid), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      push_beat(8'(i), 1'b0);
      if (i == 1) begin
        chk("t1_lat_valid", 32'(m_bus.valid), 32'd1);
        chk("t1_lat_data",  32'(m_bus.data),  32'd1);
      end
      add_exp(8'(i), (i == 4) || (i == 8));
    end
    idle();
    drain();
    compare_stream("t1");
    chk("t1_pkt", 32'(pkt_count), 32'd2);

    // Early termination by s_last.
    len = 8'd4;
    for (int i = 0; i < 7; i++) begin
      push_beat(8'h10 + 8'(i), i == 2);
      add_exp(8'h10 + 8'(i), (i == 2) || (i == 6));
    end
    idle();
    drain();
    compare_stream("t2");
    chk("t2_pkt", 32'(pkt_count), 32'd4);

    // Fill to full with the sink stalled, reject a 17th beat, then drain.
    m_bus.ready = 1'b0;
    len = 8'd8;
    for (int i = 0; i < 16; i++) begin
      push_beat(8'h20 + 8'(i), 1'b0);
      add_exp(8'h20 + 8'(i), (i == 7) || (i == 15));
    end
    chk("t3_full",      32'(full),        32'd1);
    chk("t3_s_ready",   32'(s_bus.ready), 32'd0);
    chk("t3_hold_data", 32'(m_bus.data),  32'h20);
    s_bus.valid = 1'b1;
    s_bus.data  = 8'h30;
    step(); step(); step();
    chk("t3_still_full", 32'(full),        32'd1);
    chk("t3_hold_data2", 32'(m_bus.data),  32'h20);
    idle();
    m_bus.ready = 1'b1;
    chk("t3_no_comb_ready", 32'(s_bus.ready), 32'd0);
    step();
    chk("t3_ready_rise", 32'(s_bus.ready), 32'd1);
    chk("t3_not_full",   32'(full),        32'd0);
    drain();
    compare_stream("t3");
    chk("t3_pkt", 32'(pkt_count), 32'd6);

    // len = 0 behaves as single-beat packets.
    len = 8'd0;
    for (int i = 0; i < 3; i++) begin
      push_beat(8'h40 + 8'(i), 1'b0);
      add_exp(8'h40 + 8'(i), 1'b1);
    end
    idle();
    drain();
    compare_stream("t4");
    chk("t4_pkt", 32'(pkt_count), 32'd9);

    // len change after a packet has opened only affects the next packet.
    len = 8'd4;
    push_beat(8'h50, 1'b0);
    add_exp(8'h50, 1'b0);
    idle();
    step();
    len = 8'd2;
    for (int i = 1; i <= 5; i++) begin
      push_beat(8'h50 + 8'(i), 1'b0);
      add_exp(8'h50 + 8'(i), (i == 3) || (i == 5));
    end
    idle();
    drain();
    compare_stream("t5");
    chk("t5_pkt", 32'(pkt_count), 32'd11);

    // Asynchronous reset mid-packet with five beats buffered.
    m_bus.ready = 1'b0;
    len = 8'd3;
    for (int i = 0; i < 6; i++) push_beat(8'h60 + 8'(i), 1'b0);
    idle();
    m_bus.ready = 1'b1;
    step();
    m_bus.ready = 1'b0;
    chk("t6_buffered", 32'(empty), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    obs_d.delete(); obs_l.delete();
    chk("t6_m_valid", 32'(m_bus.valid), 32'd0);
    chk("t6_empty",   32'(empty),       32'd1);
    chk("t6_pkt",     32'(pkt_count),   32'd0);
    chk("t6_s_ready", 32'(s_bus.ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    len = 8'd3;
    m_bus.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_beat(8'h70 + 8'(i), 1'b0);
      add_exp(8'h70 + 8'(i), i == 2);
    end
    idle();
    drain();
    compare_stream("t6");
    chk("t6_pkt_after", 32'(pkt_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
